alu_cmd_ctrl: RTL and testbench

Command-side controller for the ALU datapath. It accepts operation commands over a valid/ready handshake and drives the 3-bit function select and operands into the ALU function mux. It then captures the mux result and returns it with status flags over a second valid/ready handshake. It sits between the instruction/bus front end and the combinational ALU, and it is the only block that drives the mux select.

---
 rtl/alu_cmd_ctrl_pkg.sv | 25 ++
 rtl/alu_cmd_ctrl_if.sv | 39 +++
 rtl/alu_cmd_ctrl.sv | 98 +++++++++
 tb/tb_alu_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command controller and the datapath it drives.
//   - OP_* : 3-bit opcodes. These are also the ALU function-mux select codes,
//            so the controller forwards the opcode unchanged as alu_sel.
//   - state_t : command controller FSM encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;  // two's complement of A
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_RL  = 3'b110;  // rotate A left by one
  localparam logic [2:0] OP_RR  = 3'b111;  // rotate A right by one

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl_if
// Command and response handshakes between the bus front end and the ALU
// command controller.
//   cmd_valid/cmd_ready : command handshake, payload cmd_op, cmd_a, cmd_b
//   rsp_valid/rsp_ready : response handshake, payload rsp_data, rsp_op,
//                         rsp_zero, rsp_neg
// Modports:
//   master : front end (issues commands, consumes responses)
//   slave  : controller (accepts commands, produces responses)
// -----------------------------------------------------------------------------
interface alu_cmd_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_op;
  logic             rsp_zero;
  logic             rsp_neg;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_neg
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_zero, rsp_neg
  );

endinterface

// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
// Command-side controller for the combinational ALU datapath. Accepts one
// command, drives the function select and operands into the ALU mux for one
// cycle, captures the mux output and returns it with zero/negative flags.
// It is the only driver of the mux select.
//
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   CNT_W : width of the saturating completed-response counter
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : command/response handshakes (slave side)
//   alu_sel    : function select to the ALU mux (registered)
//   alu_a/b    : operands to the datapath (registered)
//   alu_result : combinational mux output, sampled only leaving EXEC
//   op_count   : number of completed responses, saturating
//
// Timing: command accepted at edge T -> operands on the datapath in the
// following cycle (EXEC) -> response valid in the cycle after that (RESP).
// A response taken at edge R leaves the controller idle in cycle R+1, so the
// peak rate is one command every 3 cycles.
// -----------------------------------------------------------------------------
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_ctrl_if.slave    bus,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CNT_W-1:0] op_count
);

  state_t state;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Gated by rst so no command can be taken while reset is held.
  assign bus.cmd_ready = (state == IDLE) && !rst;

  // The operand/select registers double as the latched command: they load on
  // accept and then hold, so the datapath inputs only change on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      alu_sel       <= 3'b000;
      alu_a         <= '0;
      alu_b         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_op    <= 3'b000;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_neg   <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        // ---- IDLE: accept a command ----
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_sel <= bus.cmd_op;
            alu_a   <= bus.cmd_a;
            alu_b   <= bus.cmd_b;
            state   <= EXEC;
          end
        end
        // ---- EXEC: datapath evaluates, capture result and flags ----
        EXEC: begin
          bus.rsp_data  <= alu_result;
          bus.rsp_zero  <= (alu_result == '0);
          bus.rsp_neg   <= alu_result[WIDTH-1];
          bus.rsp_op    <= alu_sel;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        // ---- RESP: hold response until it is taken ----
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            op_count      <= sat_inc(op_count);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
// Directed bench for alu_cmd_ctrl with WIDTH=4 and CNT_W=2. A small model of
// the ALU mux sits behind alu_result; an optional xor disturbance on that
// model shows that the result is only captured at the end of EXEC.
// -----------------------------------------------------------------------------
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [CNT_W-1:0] op_count;
  logic [WIDTH-1:0] noise;

  int n_tests;
  int n_fail;

  alu_cmd_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: the combinational function mux.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_NEG: alu_result = ~alu_a + 4'd1;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_RL:  alu_result = {alu_a[2:0], alu_a[3]};
      OP_RR:  alu_result = {alu_a[0], alu_a[3:1]};
      default: alu_result = '0;
    endcase
    alu_result = alu_result ^ noise;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
    chk({tag, "_rsp_op"},    32'(bus.rsp_op),    32'd0);
    chk({tag, "_rsp_zero"},  32'(bus.rsp_zero),  32'd0);
    chk({tag, "_rsp_neg"},   32'(bus.rsp_neg),   32'd0);
    chk({tag, "_alu_sel"},   32'(alu_sel),       32'd0);
    chk({tag, "_alu_a"},     32'(alu_a),         32'd0);
    chk({tag, "_alu_b"},     32'(alu_b),         32'd0);
    chk({tag, "_op_count"},  32'(op_count),      32'd0);
  endtask

  // Called at a negedge with the controller idle; returns at the negedge of
  // the idle cycle after the response handshake, ready for the next command.
  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_d, input logic exp_z,
                         input logic exp_n, input logic [1:0] exp_cnt);
    chk({tag, "_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    @(negedge clk);
    chk({tag, "_sel"},       32'(alu_sel),       32'(op));
    chk({tag, "_a"},         32'(alu_a),         32'(a));
    chk({tag, "_b"},         32'(alu_b),         32'(b));
    chk({tag, "_exec_vld"},  32'(bus.rsp_valid), 32'd0);
    chk({tag, "_exec_rdy"},  32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_vld"},   32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(exp_d));
    chk({tag, "_rsp_op"},    32'(bus.rsp_op),    32'(op));
    chk({tag, "_rsp_zero"},  32'(bus.rsp_zero),  32'(exp_z));
    chk({tag, "_rsp_neg"},   32'(bus.rsp_neg),   32'(exp_n));
    chk({tag, "_resp_rdy"},  32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_done_vld"},  32'(bus.rsp_valid), 32'd0);
    chk({tag, "_done_rdy"},  32'(bus.cmd_ready), 32'd1);
    chk({tag, "_count"},     32'(op_count),      32'(exp_cnt));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    noise         = 4'h0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_release_ready", 32'(bus.cmd_ready), 32'd1);

    // Add: 9 + 8 wraps to 1
    run_cmd("add", OP_ADD, 4'h9, 4'h8, 4'h1, 1'b0, 1'b0, 2'd1);
    // Sub to zero
    run_cmd("sub", OP_SUB, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 2'd2);

    // Rotate left with backpressure; disturb alu_result while held
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RL;
    bus.cmd_a     = 4'b1001;
    bus.cmd_b     = 4'h6;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rol_sel", 32'(alu_sel), 32'(OP_RL));
    @(negedge clk);
    chk("rol_data", 32'(bus.rsp_data), 32'h3);
    noise = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld",  32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data),  32'h3);
      chk("bp_op",   32'(bus.rsp_op),    32'(OP_RL));
      chk("bp_zero", 32'(bus.rsp_zero),  32'd0);
      chk("bp_neg",  32'(bus.rsp_neg),   32'd0);
      chk("bp_rdy",  32'(bus.cmd_ready), 32'd0);
      chk("bp_cnt",  32'(op_count),      32'd2);
    end
    noise = 4'h0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 32'(bus.cmd_ready), 32'd1);
    chk("bp_release_vld", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_cnt", 32'(op_count),      32'd3);

    // Reset during EXEC
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_OR;
    bus.cmd_a     = 4'hF;
    bus.cmd_b     = 4'h1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_exec");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_exec_vld",   32'(bus.rsp_valid), 32'd0);

    // Reset during RESP
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 4'h7;
    bus.cmd_b     = 4'h7;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_resp_pre_vld",  32'(bus.rsp_valid), 32'd1);
    chk("rst_resp_pre_data", 32'(bus.rsp_data),  32'hE);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_resp");
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rst_resp_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_resp_vld",   32'(bus.rsp_valid), 32'd0);
    chk("rst_resp_cnt",   32'(op_count),      32'd0);

    // Back-to-back commands covering the remaining opcodes; counter saturates
    run_cmd("and", OP_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 2'd1);
    run_cmd("neg", OP_NEG, 4'h3, 4'h9, 4'hD, 1'b0, 1'b1, 2'd2);
    run_cmd("or",  OP_OR,  4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 2'd3);
    run_cmd("xor", OP_XOR, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 2'd3);
    run_cmd("ror", OP_RR,  4'h1, 4'h5, 4'h8, 1'b0, 1'b1, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
